// File: rtl/key_debounce_pkg.sv
// Shared constants for the push-button / slide-switch input conditioner.
// Board key indices tell the display counter which channel carries which control.
package key_debounce_pkg;

    localparam int N_KEYS_DEFAULT          = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 240000;  // 20 ms at 12 MHz
    localparam int CNT_W_DEFAULT           = 18;

    localparam int KEY_HOLD  = 0;
    localparam int KEY_SET0  = 1;
    localparam int KEY_SET1  = 2;
    localparam int KEY_SPARE = 3;

endpackage

// File: rtl/key_debounce_cell.sv
// One key channel: two-FF synchroniser, stable-time counter, debounced level,
// press/release pulses and press-toggled flag.
module debounce_cell
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_down,
    output logic key_press,
    output logic key_release,
    output logic key_toggle
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             db;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b1;
            s2          <= 1'b1;
            db          <= 1'b1;
            cnt         <= '0;
            key_down    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_toggle  <= 1'b0;
        end else begin
            s1          <= key_n;
            s2          <= s1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            // Any return to the accepted level restarts the window.
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt         <= '0;
                db          <= s2;
                key_down    <= ~s2;
                key_press   <= ~s2;
                key_release <= s2;
                if (!s2) begin
                    key_toggle <= ~key_toggle;
                end
            end
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Input conditioner for the board keys: N_KEYS independent debounce channels
// feeding clean levels and edge pulses to the display counter.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS          = N_KEYS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_down,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_toggle
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .key_n       (key_n[i]),
            .key_down    (key_down[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_toggle  (key_toggle[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEBOUNCE_CYCLES=8: directed latency/boundary cases
// plus randomized key activity checked against a stable-run reference model.
module tb_key_debounce;
    import key_debounce_pkg::*;

    localparam int NK = 4;
    localparam int D  = 8;

    logic          clk;
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_down;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_toggle;

    int checks   = 0;
    int failures = 0;

    key_debounce #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_down    (key_down),
        .key_press   (key_press),
        .key_release (key_release),
        .key_toggle  (key_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pin seen two edges late; a level is accepted once it has
    // disagreed with the accepted level on D consecutive edges.
    logic [NK-1:0] m_p1, m_p2, m_db, m_down, m_press, m_rel, m_tog;
    int            m_run [NK];

    always @(posedge clk) begin
        if (rst) begin
            m_p1 = '1; m_p2 = '1; m_db = '1;
            m_down = '0; m_press = '0; m_rel = '0; m_tog = '0;
            for (int i = 0; i < NK; i++) m_run[i] = 0;
        end else begin
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < NK; i++) begin
                m_run[i] = (m_p2[i] != m_db[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == D) begin
                    m_run[i] = 0;
                    m_db[i]  = m_p2[i];
                    if (m_p2[i] == 1'b0) begin
                        m_press[i] = 1'b1;
                        m_tog[i]   = ~m_tog[i];
                    end else begin
                        m_rel[i] = 1'b1;
                    end
                end
            end
            m_down = ~m_db;
            m_p2   = m_p1;
            m_p1   = key_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        key_n = '1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int first;
        int presses;
        int ch1_pulses;
        rst   = 1'b1;
        key_n = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({key_down, key_press, key_release, key_toggle} !== 16'h0) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d outputs=%h expected 0000", c,
                         {key_down, key_press, key_release, key_toggle});
            end
        end
        key_n   = 4'b1110;
        rst     = 1'b0;
        first   = -1;
        presses = 0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (key_down[KEY_HOLD] && first < 0) first = e;
            if (key_press[KEY_HOLD]) presses++;
        end
        checks++;
        if (first != 10) begin
            failures++;
            $display("FAIL reset_exit_latency edge=%0d expected 10", first);
        end
        checks++;
        if (presses != 1) begin
            failures++;
            $display("FAIL reset_exit_press count=%0d expected 1", presses);
        end
        ch1_pulses = 0;
        key_n[KEY_SET0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            ch1_pulses += int'(key_press[KEY_SET0]) + int'(key_release[KEY_SET0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        key_n[KEY_SET0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            ch1_pulses += int'(key_press[KEY_SET0]) + int'(key_release[KEY_SET0]);
        end
        checks++;
        if (ch1_pulses != 0 || key_down[KEY_SET0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_count pulses=%0d down=%b expected 0 0",
                     ch1_pulses, key_down[KEY_SET0]);
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        key_n[KEY_HOLD] = 1'b0;
        for (int e = 0; e <= 52; e++) begin
            if (e == 40) key_n[KEY_HOLD] = 1'b1;
            tick();
            if (e == 8) begin
                checks++;
                if (key_down[0] !== 1'b0 || key_press[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL press_early e8 down=%b press=%b expected 0 0",
                             key_down[0], key_press[0]);
                end
            end
            if (e == 9) begin
                checks++;
                if (key_down[0] !== 1'b1 || key_press[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL press_edge e9 down=%b press=%b expected 1 1",
                             key_down[0], key_press[0]);
                end
            end
            if (e == 10) begin
                checks++;
                if (key_down[0] !== 1'b1 || key_press[0] !== 1'b0 || key_toggle[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL press_after e10 down=%b press=%b toggle=%b expected 1 0 1",
                             key_down[0], key_press[0], key_toggle[0]);
                end
            end
            if (e == 48) begin
                checks++;
                if (key_release[0] !== 1'b0 || key_down[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL release_early e48 release=%b down=%b expected 0 1",
                             key_release[0], key_down[0]);
                end
            end
            if (e == 49) begin
                checks++;
                if (key_release[0] !== 1'b1 || key_down[0] !== 1'b0 || key_toggle[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL release_edge e49 release=%b down=%b toggle=%b expected 1 0 1",
                             key_release[0], key_down[0], key_toggle[0]);
                end
            end
            if (e == 50) begin
                checks++;
                if (key_release[0] !== 1'b0 || key_toggle[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL release_after e50 release=%b toggle=%b expected 0 1",
                             key_release[0], key_toggle[0]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int bad;
        do_reset();
        bad = 0;
        key_n[KEY_SET1] = 1'b0;
        for (int e = 0; e < 30; e++) begin
            if (e == 7) key_n[KEY_SET1] = 1'b1;
            tick();
            if ((key_down[KEY_SET1] | key_press[KEY_SET1] | key_toggle[KEY_SET1]) !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL glitch_7 bad_cycles=%0d expected 0", bad);
        end
    endtask

    task automatic test_bounce();
        int presses;
        int first;
        do_reset();
        presses = 0;
        first   = -1;
        for (int e = 0; e < 40; e++) begin
            key_n[KEY_SET0] = (e >= 5 && e < 7) ? 1'b1 : 1'b0;
            tick();
            if (key_press[KEY_SET0]) begin
                presses++;
                if (first < 0) first = e;
            end
        end
        checks++;
        if (presses != 1 || first != 16) begin
            failures++;
            $display("FAIL bounce_restart presses=%0d edge=%0d expected 1 16", presses, first);
        end
        checks++;
        if (key_down[KEY_SET0] !== 1'b1) begin
            failures++;
            $display("FAIL bounce_level down=%b expected 1", key_down[KEY_SET0]);
        end
    endtask

    task automatic test_toggle();
        int presses;
        int releases;
        logic [2:0] togs;
        do_reset();
        presses  = 0;
        releases = 0;
        togs     = 3'b000;
        for (int p = 0; p < 3; p++) begin
            key_n[KEY_SPARE] = 1'b0;
            repeat (15) begin
                tick();
                if (key_press[KEY_SPARE]) begin
                    if (presses < 3) togs[presses] = key_toggle[KEY_SPARE];
                    presses++;
                end
                if (key_release[KEY_SPARE]) releases++;
            end
            key_n[KEY_SPARE] = 1'b1;
            repeat (15) begin
                tick();
                if (key_press[KEY_SPARE]) presses++;
                if (key_release[KEY_SPARE]) releases++;
            end
        end
        checks++;
        if (togs !== 3'b101) begin
            failures++;
            $display("FAIL toggle_seq got=%b expected 101 (press order lsb first)", togs);
        end
        checks++;
        if (presses != 3 || releases != 3) begin
            failures++;
            $display("FAIL toggle_pulses press=%0d release=%0d expected 3 3", presses, releases);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        int at;
        logic [NK-1:0] seen;
        int overlap;
        do_reset();
        n = 0; at = -1; seen = '0; overlap = 0;
        key_n = 4'b0000;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (key_press != '0) begin
                n++;
                seen = key_press;
                at   = e;
            end
            if (key_release != '0) overlap++;
        end
        checks++;
        if (n != 1 || seen !== 4'hF || at != 9) begin
            failures++;
            $display("FAIL simultaneous cycles=%0d press=%b edge=%0d expected 1 1111 9", n, seen, at);
        end
        checks++;
        if (overlap != 0 || key_down !== 4'hF || key_toggle !== 4'hF) begin
            failures++;
            $display("FAIL simultaneous_state releases=%0d down=%b toggle=%b expected 0 1111 1111",
                     overlap, key_down, key_toggle);
        end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NK; i++)
                if ($urandom_range(0, 9) == 0) key_n[i] = ~key_n[i];
            rst = ($urandom_range(0, 399) == 0);
            tick();
            checks++;
            if ({key_down, key_press, key_release, key_toggle} !==
                {m_down, m_press, m_rel, m_tog} || (key_press & key_release) != '0) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cycle=%0d dut=%h model=%h", c,
                             {key_down, key_press, key_release, key_toggle},
                             {m_down, m_press, m_rel, m_tog});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        key_n = '1;
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_toggle();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
